// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side front end: default widths,
// skid-buffer state encoding and a Gray-to-binary helper.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_PTR_WIDTH  = 3;

    // Skid-buffer occupancy states (value equals number of held words)
    localparam int         SKID_STATE_W = 2;
    localparam logic [1:0] SKID_EMPTY   = 2'd0;
    localparam logic [1:0] SKID_ONE     = 2'd1;
    localparam logic [1:0] SKID_TWO     = 2'd2;

    // Gray-to-binary for codes up to 32 bits; narrower codes are
    // zero-extended by the caller, which leaves the low bits correct.
    function automatic logic [31:0] gray_to_bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary converter, WIDTH up to 32 bits.
module gray2bin
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_PTR_WIDTH + 1
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    assign o_bin = WIDTH'(gray_to_bin(32'(i_gray)));

endmodule

// File: rtl/fifo_wr_frontend.sv
// FIFO write-side front end: a 2-entry skid buffer that turns an upstream
// valid/ready stream into memory write strobes gated by the full flag, plus
// an optional registered fill level / almost-full computation.
// Optional feature macro: FIFO_WR_LEVEL_EN (level logic; default build ties
// o_level and o_almost_full to 0).
module fifo_wr_frontend
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PTR_WIDTH  = DEFAULT_PTR_WIDTH,
    parameter int AF_MARGIN  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic                    o_ready,
    output logic                    o_wr_en,
    output logic [DATA_WIDTH-1:0]   o_wr_data,
    input  logic                    i_full,
    input  logic [PTR_WIDTH:0]      i_b_wr_ptr,
    input  logic [PTR_WIDTH:0]      i_g_rd_ptr_sync,
    output logic [PTR_WIDTH:0]      o_level,
    output logic                    o_almost_full,
    output logic [SKID_STATE_W-1:0] o_skid_state
);

    localparam int               DEPTH     = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] AF_THRESH = (PTR_WIDTH + 1)'(DEPTH - AF_MARGIN);

    // Handshake: a word moves from upstream on a rising edge where
    // i_valid=1 and o_ready=1; upstream must hold i_valid/i_data stable until
    // then. o_ready is a flop, so it never depends on i_valid in the same
    // cycle. Downstream has no ready: a memory write happens in every cycle
    // with o_wr_en=1, which is only raised while i_full=0.

    logic [SKID_STATE_W-1:0] state_q, state_d;
    logic [DATA_WIDTH-1:0]   head_q, head_d;   // oldest held word
    logic [DATA_WIDTH-1:0]   tail_q, tail_d;   // second word, only valid in TWO
    logic                    ready_q;
    logic                    transfer;
    logic                    write;

    assign transfer = i_valid & ready_q;
    assign write    = (state_q != SKID_EMPTY) & ~i_full;

    assign o_ready      = ready_q;
    assign o_wr_en      = write;
    assign o_wr_data    = head_q;
    assign o_skid_state = state_q;

    // Next-state and data movement of the skid buffer
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            SKID_EMPTY: begin
                if (transfer) begin
                    state_d = SKID_ONE;
                    head_d  = i_data;
                end
            end
            SKID_ONE: begin
                case ({transfer, write})
                    2'b10: begin
                        state_d = SKID_TWO;
                        tail_d  = i_data;
                    end
                    2'b01: begin
                        state_d = SKID_EMPTY;
                    end
                    2'b11: begin
                        // head leaves and the new word becomes head
                        head_d = i_data;
                    end
                    default: begin
                    end
                endcase
            end
            SKID_TWO: begin
                // ready is low here, so only a write can happen
                if (write) begin
                    state_d = SKID_ONE;
                    head_d  = tail_q;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
    end

    // Skid buffer registers; ready is derived from the next state so that
    // back-pressure appears in the cycle the buffer becomes TWO
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= SKID_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= (state_d != SKID_TWO);
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    logic [PTR_WIDTH:0] rd_bin;
    logic [PTR_WIDTH:0] level_d;

    gray2bin #(
        .WIDTH (PTR_WIDTH + 1)
    ) u_gray2bin (
        .i_gray (i_g_rd_ptr_sync),
        .o_bin  (rd_bin)
    );

    // Modular subtraction handles pointer wrap-around naturally
    assign level_d = i_b_wr_ptr - rd_bin;

    // Registered fill level and almost-full flag
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_level       <= '0;
            o_almost_full <= 1'b0;
        end else begin
            o_level       <= level_d;
            o_almost_full <= (level_d >= AF_THRESH);
        end
    end
`else
    // Level logic absent: ports stay, outputs are constant
    logic unused_level_inputs;

    assign o_level             = '0;
    assign o_almost_full       = 1'b0;
    assign unused_level_inputs = ^{i_b_wr_ptr, i_g_rd_ptr_sync, AF_THRESH};
`endif

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Self-checking bench for fifo_wr_frontend: queue-based model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fifo_wr_frontend;

    localparam int DW    = 8;
    localparam int PW    = 3;
    localparam int DEPTH = 8;
    localparam int AFM   = 1;

    logic          clk;
    logic          rstn;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic [PW:0]   b_wr_ptr;
    logic [PW:0]   g_rd_ptr;
    logic [PW:0]   level;
    logic          almost_full;
    logic [1:0]    skid_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model state
    logic [DW-1:0] exp_q[$];
    logic          m_ready = 1'b0;
    logic [PW:0]   m_level = '0;
    logic          m_af    = 1'b0;

    // observed writes, for directed checks
    logic [DW-1:0] wr_log[$];
    int            wr_cyc[$];

    fifo_wr_frontend #(
        .DATA_WIDTH (DW),
        .PTR_WIDTH  (PW),
        .AF_MARGIN  (AFM)
    ) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_valid         (valid),
        .i_data          (data),
        .o_ready         (ready),
        .o_wr_en         (wr_en),
        .o_wr_data       (wr_data),
        .i_full          (full),
        .i_b_wr_ptr      (b_wr_ptr),
        .i_g_rd_ptr_sync (g_rd_ptr),
        .o_level         (level),
        .o_almost_full   (almost_full),
        .o_skid_state    (skid_state)
    );

    // clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW:0] to_gray(input logic [PW:0] b);
        return b ^ (b >> 1);
    endfunction

    // decode by searching for the binary value whose Gray code matches
    function automatic logic [PW:0] from_gray(input logic [PW:0] g);
        for (int x = 0; x < 2 ** (PW + 1); x++) begin
            if (to_gray((PW + 1)'(x)) == g) return (PW + 1)'(x);
        end
        return '0;
    endfunction

    // compare process: check outputs against the model, then advance the
    // model to what the coming rising edge must produce
    always @(negedge clk) begin
        logic        exp_wr;
        int          lvl;
        if (!rstn) begin
            exp_q.delete();
            m_ready = 1'b0;
            m_level = '0;
            m_af    = 1'b0;
        end
        exp_wr = (exp_q.size() > 0) && !full;
        chk("model_ready", ready, m_ready);
        chk("model_wr_en", wr_en, exp_wr);
        if (exp_wr && wr_en) chk("model_wr_data", wr_data, exp_q[0]);
        chk("model_level", level, m_level);
        chk("model_almost_full", almost_full, m_af);
        if (wr_en) begin
            wr_log.push_back(wr_data);
            wr_cyc.push_back(cyc);
        end
        if (rstn) begin
            if (exp_wr) void'(exp_q.pop_front());
            if (valid && m_ready) exp_q.push_back(data);
            m_ready = (exp_q.size() < 2);
`ifdef FIFO_WR_LEVEL_EN
            lvl     = (int'(b_wr_ptr) - int'(from_gray(g_rd_ptr)) + 2 ** (PW + 1)) % (2 ** (PW + 1));
            m_level = (PW + 1)'(lvl);
            m_af    = (lvl >= DEPTH - AFM);
`else
            lvl     = 0;
            m_level = '0;
            m_af    = 1'b0;
`endif
        end
    end

    // offer one word and hold it until accepted
    task automatic drive_word(input logic [DW-1:0] d);
        logic r;
        int   n;
        valid = 1'b1;
        data  = d;
        n     = 0;
        forever begin
            @(negedge clk);
            r = ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL drive_timeout: word 0x%0h not accepted after %0d cycles", d, n);
                break;
            end
        end
    endtask

    task automatic set_ptrs_and_check(input string name, input logic [PW:0] wr, input logic [PW:0] rd_bin,
                                      input logic [PW:0] exp_lvl, input logic exp_af);
        b_wr_ptr = wr;
        g_rd_ptr = to_gray(rd_bin);
        @(posedge clk);
        @(negedge clk);
`ifdef FIFO_WR_LEVEL_EN
        chk({name, "_level"}, level, exp_lvl);
        chk({name, "_af"}, almost_full, exp_af);
`else
        chk({name, "_level_off"}, level, 0);
        chk({name, "_af_off"}, almost_full, 0);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   sent;
        int   bad;
        logic x;
        rstn     = 1'b0;
        valid    = 1'b0;
        data     = '0;
        full     = 1'b0;
        b_wr_ptr = '0;
        g_rd_ptr = '0;

        // reset state
        #12;
        chk("rst_ready", ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_level", level, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_state", skid_state, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rel_ready_before_edge", ready, 0);
        @(posedge clk);
        #1;
        chk("rel_ready_first_edge", ready, 1);

        // streaming 0x01..0x08 with i_full=0
        wr_log.delete();
        wr_cyc.delete();
        for (int i = 1; i <= 8; i++) drive_word(DW'(i));
        valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stream_count", wr_log.size(), 8);
        if (wr_log.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("stream_word", wr_log[i], i + 1);
            chk("stream_back_to_back", wr_cyc[7] - wr_cyc[0], 7);
        end

        // back-pressure while full
        wr_log.delete();
        full = 1'b1;
        drive_word(8'hA0);
        drive_word(8'hA1);
        valid = 1'b1;
        data  = 8'hA2;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready", ready, 0);
        chk("bp_wr_en", wr_en, 0);
        chk("bp_state_two", skid_state, 2);
        chk("bp_no_writes", wr_log.size(), 0);
        full = 1'b0;
        drive_word(8'hA2);
        valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            chk("bp_word0", wr_log[0], 8'hA0);
            chk("bp_word1", wr_log[1], 8'hA1);
            chk("bp_word2", wr_log[2], 8'hA2);
        end

        // random valid, full toggling every cycle, random pointers
        wr_log.delete();
        sent = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            @(negedge clk);
            x = valid && ready;
            @(posedge clk);
            #1;
            if (x) sent++;
            full = ~full;
            if (!(valid && !x)) begin
                valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
                data  = DW'(sent);
            end
            b_wr_ptr = (PW + 1)'($urandom_range(0, 15));
            g_rd_ptr = (PW + 1)'($urandom_range(0, 15));
        end
        valid = 1'b0;
        full  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rand_sent", sent, 1000);
        chk("rand_written", wr_log.size(), 1000);
        chk("rand_model_empty", exp_q.size(), 0);
        bad = 0;
        for (int i = 0; i < wr_log.size(); i++) begin
            if (wr_log[i] !== DW'(i)) bad++;
        end
        chk("rand_order_errors", bad, 0);

        // level and almost-full, including wrap-around and full depth
        set_ptrs_and_check("lvl6", 4'b0110, 4'b0000, 4'd6, 1'b0);
        set_ptrs_and_check("lvl7", 4'b0111, 4'b0000, 4'd7, 1'b1);
        set_ptrs_and_check("wrap6", 4'b0010, 4'b1100, 4'd6, 1'b0);
        set_ptrs_and_check("wrap2", 4'b0001, 4'b1111, 4'd2, 1'b0);
        set_ptrs_and_check("lvl8", 4'b1000, 4'b0000, 4'd8, 1'b1);
        set_ptrs_and_check("lvl0", 4'b1011, 4'b1011, 4'd0, 1'b0);

        // asynchronous reset while holding two words
        wr_log.delete();
        full = 1'b1;
        drive_word(8'h55);
        drive_word(8'h66);
        valid = 1'b0;
        @(posedge clk);
        #1;
        full = 1'b0;
        #1;
        chk("pre_rst_state_two", skid_state, 2);
        chk("pre_rst_wr_en", wr_en, 1);
        chk("pre_rst_ready", ready, 0);
        rstn = 1'b0;
        #1;
        chk("async_rst_wr_en", wr_en, 0);
        chk("async_rst_ready", ready, 0);
        chk("async_rst_state", skid_state, 0);
        chk("async_rst_wr_data", wr_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        wr_log.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_ready", ready, 1);
        chk("post_rst_no_stale_write", wr_log.size(), 0);
        chk("post_rst_state", skid_state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
